// File: rtl/uart_tx_framer_if.sv
// Host-side bundle for uart_tx_framer: frame request, payload, parity inputs and line status.
// UART_TX_STOP2_EN adds the stop_bits select.
interface uart_tx_framer_if;
  logic       tx_start;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       parity_bit;
`ifdef UART_TX_STOP2_EN
  logic       stop_bits;
`endif
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

`ifdef UART_TX_STOP2_EN
  modport master (output tx_start, data_in, parity_type, parity_bit, stop_bits,
                  input  tx_out, tx_busy, tx_done);
  modport slave  (input  tx_start, data_in, parity_type, parity_bit, stop_bits,
                  output tx_out, tx_busy, tx_done);
`else
  modport master (output tx_start, data_in, parity_type, parity_bit,
                  input  tx_out, tx_busy, tx_done);
  modport slave  (input  tx_start, data_in, parity_type, parity_bit,
                  output tx_out, tx_busy, tx_done);
`endif
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to enable the per-frame two-stop-bit option.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clock,
  input  logic            reset_n,
  uart_tx_framer_if.slave bus
);
  localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    ptype_q, ptype_d;
  logic          pbit_q, pbit_d;
  logic          stop2_q, stop2_d;
  logic          stop_idx_q, stop_idx_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic          bit_end;
  logic [2:0]    nxt_idx;
  logic          stop2_in;

`ifdef UART_TX_STOP2_EN
  assign stop2_in = bus.stop_bits;
`else
  assign stop2_in = 1'b0;
`endif

  always_comb begin
    bit_end    = (baud_q == BAUD_LAST);
    nxt_idx    = bit_idx_q + 3'd1;
    state_d    = state_q;
    baud_d     = (state_q == S_IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    ptype_d    = ptype_q;
    pbit_d     = pbit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    tx_out_d   = tx_out_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_out_d  = 1'b1;
        tx_busy_d = 1'b0;
        if (bus.tx_start) begin
          // Everything the frame needs is snapshotted here; inputs are free to move afterwards.
          state_d    = S_START;
          data_d     = bus.data_in;
          ptype_d    = bus.parity_type;
          pbit_d     = bus.parity_bit;
          stop2_d    = stop2_in;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          tx_out_d   = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      S_START: if (bit_end) begin
        state_d  = S_DATA;
        tx_out_d = data_q[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_idx_q == 3'd7) begin
          bit_idx_d = 3'd0;
          if (ptype_q == 2'b00) begin
            state_d  = S_STOP;
            tx_out_d = 1'b1;
          end else begin
            state_d  = S_PARITY;
            tx_out_d = pbit_q;
          end
        end else begin
          bit_idx_d = nxt_idx;
          tx_out_d  = data_q[nxt_idx];
        end
      end
      S_PARITY: if (bit_end) begin
        state_d  = S_STOP;
        tx_out_d = 1'b1;
      end
      S_STOP: if (bit_end) begin
        if (stop2_q && !stop_idx_q) begin
          stop_idx_d = 1'b1;
        end else begin
          state_d    = S_IDLE;
          stop_idx_d = 1'b0;
          tx_busy_d  = 1'b0;
          tx_done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        tx_out_d  = 1'b1;
        tx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'h00;
      ptype_q    <= 2'b00;
      pbit_q     <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      ptype_q    <= ptype_d;
      pbit_q     <= pbit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign bus.tx_out  = tx_out_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;
endmodule
